// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, counter debounce,
// registered rise/fall pulses and optional hold-to-auto-repeat per channel.
module btn_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_async,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_repeat
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_state_e;

    if (CHANNELS < 1) begin : gen_bad_channels
        $error("CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : gen_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 2) begin : gen_bad_hold
        $error("HOLD_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : gen_bad_repeat
        $error("REPEAT_CYCLES must be >= 2");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic                   s;
        logic                   level_q, level_d;
        logic [DW-1:0]          dcnt_q, dcnt_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        assign sync_d = {sync_q[SYNC_STAGES-2:0], i_async[c]};
        assign s      = sync_q[SYNC_STAGES-1];

        // Any sample matching the current level restarts the stability count.
        always_comb begin
            level_d = level_q;
            dcnt_d  = '0;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s != level_q) begin
                if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                level_q <= 1'b0;
                dcnt_q  <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                level_q <= level_d;
                dcnt_q  <= dcnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign o_level[c] = level_q;
        assign o_rise[c]  = rise_q;
        assign o_fall[c]  = fall_q;

        if (REPEAT_EN != 0) begin : gen_rpt
            rpt_state_e state_q, state_d;
            logic [RW-1:0] rcnt_q, rcnt_d;
            logic          rpt_q, rpt_d;

            // Keyed off the same edge that updates the level, so the hold
            // period is counted from the o_rise cycle.
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                rpt_d   = 1'b0;
                if (fall_d) begin
                    state_d = StIdle;
                    rcnt_d  = '0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (rise_d) begin
                                state_d = StHold;
                                rcnt_d  = '0;
                            end
                        end
                        StHold: begin
                            if (rcnt_q == RW'(HOLD_CYCLES - 1)) begin
                                rpt_d   = 1'b1;
                                rcnt_d  = '0;
                                state_d = StRepeat;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        StRepeat: begin
                            if (rcnt_q == RW'(REPEAT_CYCLES - 1)) begin
                                rpt_d  = 1'b1;
                                rcnt_d = '0;
                            end else begin
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d = StIdle;
                            rcnt_d  = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= StIdle;
                    rcnt_q  <= '0;
                    rpt_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rcnt_q  <= rcnt_d;
                    rpt_q   <= rpt_d;
                end
            end

            assign o_repeat[c] = rpt_q;
        end else begin : gen_no_rpt
            assign o_repeat[c] = 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a default instance driven from a vector
// table plus multi-cycle sequences, and a no-filter/no-repeat instance.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] in1, in2;
    logic [3:0] level1, rise1, fall1, rpt1;
    logic [3:0] level2, rise2, fall2, rpt2;

    btn_conditioner u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_async  (in1),
        .o_level  (level1),
        .o_rise   (rise1),
        .o_fall   (fall1),
        .o_repeat (rpt1)
    );

    btn_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .REPEAT_EN       (0),
        .HOLD_CYCLES     (64),
        .REPEAT_CYCLES   (16)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .i_async  (in2),
        .o_level  (level2),
        .o_rise   (rise2),
        .o_fall   (fall2),
        .o_repeat (rpt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int rise_cnt[4], rise_at[4], fall_cnt[4], fall_at[4], rep_cnt[4], rep_first[4];
    int rise2_cnt[4], rise2_at[4], fall2_at[4], rep2_total;
    int overlap;
    int rep1_q[$];
    int rep3_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0; rise_at[i] = -1; fall_cnt[i] = 0; fall_at[i] = -1;
            rep_cnt[i] = 0; rep_first[i] = -1;
            rise2_cnt[i] = 0; rise2_at[i] = -1; fall2_at[i] = -1;
        end
        rep2_total = 0;
        rep1_q.delete();
        rep3_q.delete();
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (rise1[i]) begin rise_cnt[i]++; rise_at[i] = cyc; end
            if (fall1[i]) begin fall_cnt[i]++; fall_at[i] = cyc; end
            if (rpt1[i]) begin
                if (rep_cnt[i] == 0) rep_first[i] = cyc;
                rep_cnt[i]++;
            end
            if (rise2[i]) begin rise2_cnt[i]++; rise2_at[i] = cyc; end
            if (fall2[i]) fall2_at[i] = cyc;
            if (rpt2[i]) rep2_total++;
        end
        if (rpt1[1]) rep1_q.push_back(cyc);
        if (rpt1[3]) rep3_q.push_back(cyc);
        if ((rise1 & rpt1) != 4'h0 || (rise1 & fall1) != 4'h0) overlap++;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] in;
        int         n;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] rpt;
    } vec_t;

    vec_t tbl[13];
    int   t0, t1, tg;

    initial begin
        tbl[0]  = '{1'b1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 17, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'hF,  1, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'hF, 63, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{1'b0, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'hF};
        tbl[5]  = '{1'b0, 4'hF, 15, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[6]  = '{1'b0, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'hF};
        tbl[7]  = '{1'b1, 4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{1'b0, 4'hF, 17, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 4'hF,  1, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[10] = '{1'b0, 4'h0, 17, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 4'h0,  1, 4'h0, 4'h0, 4'hF, 4'h0};
        tbl[12] = '{1'b0, 4'h0,  5, 4'h0, 4'h0, 4'h0, 4'h0};

        overlap = 0;
        clear_log();
        in2 = 4'h0;

        // Reset with inputs held high, repeats, mid-run reset, release.
        for (int r = 0; r < 13; r++) begin
            rst = tbl[r].rst;
            in1 = tbl[r].in;
            for (int k = 0; k < tbl[r].n; k++) begin
                step();
                chk($sformatf("tbl%0d.level", r), int'(level1), int'(tbl[r].lvl));
                chk($sformatf("tbl%0d.rise", r), int'(rise1), int'(tbl[r].rise));
                chk($sformatf("tbl%0d.fall", r), int'(fall1), int'(tbl[r].fall));
                chk($sformatf("tbl%0d.repeat", r), int'(rpt1), int'(tbl[r].rpt));
            end
        end

        // ch0: 10-cycle glitch, gap, then a stable press.
        clear_log();
        in1[0] = 1'b1;
        repeat (10) step();
        in1[0] = 1'b0;
        repeat (5) step();
        in1[0] = 1'b1;
        t0 = cyc;
        repeat (30) step();
        chk("glitch.rise_cnt", rise_cnt[0], 1);
        chk("glitch.rise_at", rise_at[0], t0 + 18);
        chk("glitch.fall_cnt", fall_cnt[0], 0);
        chk("glitch.level", int'(level1[0]), 1);
        in1[0] = 1'b0;
        repeat (25) step();
        chk("glitch.released", int'(level1[0]), 0);

        // ch1 and ch3 held 200 cycles while ch2 toggles every 8 cycles.
        clear_log();
        t0 = cyc;
        in1 = 4'b1010;
        for (int i = 0; i < 200; i++) begin
            step();
            if ((i + 1) % 8 == 0) in1[2] = ~in1[2];
        end
        in1 = 4'b0000;
        repeat (60) step();
        chk("hold.rise1_at", rise_at[1], t0 + 18);
        chk("hold.rise3_at", rise_at[3], t0 + 18);
        chk("hold.rep1_cnt", rep1_q.size(), 9);
        chk("hold.rep3_cnt", rep3_q.size(), 9);
        if (rep1_q.size() == 9 && rep3_q.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("hold.rep1_t%0d", k), rep1_q[k], t0 + 82 + 16 * k);
                chk($sformatf("hold.rep3_t%0d", k), rep3_q[k], t0 + 82 + 16 * k);
            end
        end
        chk("hold.fall1_at", fall_at[1], t0 + 218);
        chk("hold.fall3_at", fall_at[3], t0 + 218);
        chk("hold.ch2_rise", rise_cnt[2], 0);
        chk("hold.ch2_fall", fall_cnt[2], 0);
        chk("hold.ch2_rep", rep_cnt[2], 0);

        // ch0: level falls on the edge the second repeat is due.
        clear_log();
        t0 = cyc;
        in1[0] = 1'b1;
        repeat (80) step();
        in1[0] = 1'b0;
        repeat (40) step();
        chk("coinc.rise_at", rise_at[0], t0 + 18);
        chk("coinc.rep_cnt", rep_cnt[0], 1);
        chk("coinc.rep_first", rep_first[0], t0 + 82);
        chk("coinc.fall_at", fall_at[0], t0 + 98);
        // A fresh press must see the full hold time again.
        clear_log();
        t1 = cyc;
        in1[0] = 1'b1;
        repeat (90) step();
        chk("repress.rise_at", rise_at[0], t1 + 18);
        chk("repress.rep_first", rep_first[0], t1 + 82);
        chk("repress.rep_cnt", rep_cnt[0], 1);
        in1[0] = 1'b0;
        repeat (25) step();

        // No-filter instance with 3-stage synchroniser and repeat disabled.
        clear_log();
        t0 = cyc;
        in2 = 4'b0011;
        repeat (120) step();
        chk("nf.rise_at", rise2_at[0], t0 + 4);
        chk("nf.rise_cnt", rise2_cnt[0], 1);
        chk("nf.level", int'(level2), 3);
        t1 = cyc;
        in2 = 4'b0000;
        repeat (10) step();
        chk("nf.fall_at", fall2_at[0], t1 + 4);
        tg = cyc;
        in2[2] = 1'b1;
        step();
        in2[2] = 1'b0;
        repeat (10) step();
        chk("nf.pulse_rise", rise2_at[2], tg + 4);
        chk("nf.pulse_fall", fall2_at[2], tg + 5);
        chk("nf.repeat_total", rep2_total, 0);

        chk("overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel input conditioner for asynchronous push-buttons and switches. Each channel gets a parametrised-depth synchroniser, a counter-based debounce filter, registered rise/fall pulses and an optional hold-to-auto-repeat generator. It sits between board I/O and control logic, such as DDS frequency step, mode select or filter coefficient select, so that one press produces exactly one pulse, with optional repeats while the button is held.

## Interface
Parameters:
- CHANNELS, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flip-flop depth (>=2)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a new level (>=1)
- REPEAT_EN, 1, 1 enables the auto-repeat generator; 0 ties o_repeat to 0 and removes the logic
- HOLD_CYCLES, 64, cycles from the o_rise pulse to the first o_repeat pulse (>=2)
- REPEAT_CYCLES, 16, period of subsequent o_repeat pulses (>=2)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous, active-high reset
- i_async, input, CHANNELS, asynchronous raw inputs, active-high
- o_level, output, CHANNELS, debounced level per channel
- o_rise, output, CHANNELS, 1-cycle pulse when o_level goes 0->1
- o_fall, output, CHANNELS, 1-cycle pulse when o_level goes 1->0
- o_repeat, output, CHANNELS, 1-cycle auto-repeat pulses while the button is held

## Operation
- Channels are fully independent and share no state.
- Synchroniser: a chain of SYNC_STAGES flip-flops, reset to 0. All chain flip-flops carry the ASYNC_REG attribute. The last stage is s.
- Debounce: each channel has a counter dcnt of width clog2(DEBOUNCE_CYCLES+1) and a level register L.
  - If s==L: dcnt<=0.
  - Else if dcnt==DEBOUNCE_CYCLES-1: L<=s and dcnt<=0.
  - Else: dcnt<=dcnt+1.
  - A differing run shorter than DEBOUNCE_CYCLES leaves L unchanged, and the counter restarts from 0.
  - DEBOUNCE_CYCLES=1 means no filtering.
- o_level = L.
- o_rise and o_fall are registered. They are set on the same edge that L changes, so they are high during the first cycle of the new level and are never high together.
- Repeat FSM (REPEAT_EN=1), per channel, with states IDLE, HOLD and REPEAT, and a counter rcnt:
  - IDLE: on the edge L goes 1, move to HOLD with rcnt=0.
  - HOLD: if rcnt==HOLD_CYCLES-1, pulse o_repeat, set rcnt=0 and move to REPEAT. Otherwise rcnt++.
  - REPEAT: if rcnt==REPEAT_CYCLES-1, pulse o_repeat and set rcnt=0. Otherwise rcnt++.
  - In any state, on the edge L goes 0: move to IDLE, set rcnt=0, no o_repeat. Release wins over a coincident repeat.
- Illegal parameter values (SYNC_STAGES<2, DEBOUNCE_CYCLES<1, HOLD_CYCLES<2, REPEAT_CYCLES<2) cause an elaboration error.

## Timing
- Reset values: all synchroniser flip-flops, L, dcnt and rcnt are 0; every FSM is in IDLE; o_level, o_rise, o_fall and o_repeat are all 0.
- Latency: call the first clock edge that samples a new stable i_async value edge 0. L changes, with o_rise or o_fall asserted, immediately after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With the defaults this is edge 17.
- First o_repeat is exactly HOLD_CYCLES cycles after the o_rise cycle. Later pulses follow every REPEAT_CYCLES cycles.
- o_rise is never coincident with o_repeat.
- Reset during operation clears everything immediately. An input held high across reset release is treated as a new press, with o_rise after the full latency.
- Input glitches shorter than the synchroniser window, or shorter than DEBOUNCE_CYCLES, produce no output activity.

## Test plan
- Reset with i_async=4'b1111 held: all outputs are 0 during rst. After release, ch0..3 o_rise pulse together immediately after edge 17, and o_level=4'b1111.
- ch0 raw 1 for 10 cycles, then 0, then 1 stable: no pulse from the 10-cycle glitch. A single o_rise occurs 17 edges after the final rise, with no o_fall anywhere.
- ch1 held high for 200 cycles (defaults):
  - o_rise at cycle r.
  - o_repeat at r+64, r+80, r+96, and so on.
  - On release, o_fall after 17 edges and no further o_repeat.
- Release timed so that L falls on the same edge a repeat is due: o_fall=1, o_repeat=0, and the FSM returns to IDLE.
- ch2 toggling every 8 cycles while ch3 is held: ch2 outputs stay 0, and ch3 timing is identical to the isolated case.
- REPEAT_EN=0, DEBOUNCE_CYCLES=1, SYNC_STAGES=3: o_rise follows 3 edges after the input edge, and o_repeat is always 0.
